video_pattern_gen: RTL

Parametrised test-pattern source for the video output path. It walks an explicit H_ACTIVE x V_ACTIVE raster and advances one pixel per accepted beat (VideoReady). It produces one of several selectable 24-bit RGB patterns for bring-up of the display, DVI and frame-buffer paths ahead of the SIFT pipeline. Frame and line markers let downstream logic align to the raster.

---
 rtl/video_pattern_pkg.sv | 53 +++++
 rtl/video_pattern_gen_raster_counter.sv | 42 ++++
 rtl/video_pattern_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/video_pattern_pkg.sv
// Shared mode encodings, pixel payload type and colour tables for the video pattern source.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER  = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_SOLID    = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t P0 = '{r: 8'd26,  g: 8'd188, b: 8'd156};
  localparam rgb_t P1 = '{r: 8'd230, g: 8'd126, b: 8'd34};
  localparam rgb_t P2 = '{r: 8'd241, g: 8'd196, b: 8'd15};
  localparam rgb_t P3 = '{r: 8'd192, g: 8'd57,  b: 8'd43};

  localparam rgb_t BAR_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BAR_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t BAR_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BAR_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t BAR_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_t BAR_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t BAR_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t BAR_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

  function automatic rgb_t palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = P0;
      2'd1:    palette = P1;
      2'd2:    palette = P2;
      default: palette = P3;
    endcase
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_raster_counter.sv
// Reusable raster position counter: walks x/y one pixel per accepted beat and
// flags frame start, line end and the line/frame-end accept strobes.
module raster_counter #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned XW       = $clog2(H_ACTIVE),
  parameter int unsigned YW       = $clog2(V_ACTIVE)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          VideoReady,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sof_c,
  output logic          eol_c,
  output logic          line_end_c,
  output logic          frame_end_c
);

  logic last_line_c;

  assign eol_c       = (x == XW'(H_ACTIVE - 1));
  assign last_line_c = (y == YW'(V_ACTIVE - 1));
  assign sof_c       = (x == '0) && (y == '0);
  assign line_end_c  = VideoReady && eol_c;
  assign frame_end_c = line_end_c && last_line_c;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x <= '0;
      y <= '0;
    end else if (VideoReady) begin
      if (eol_c) begin
        x <= '0;
        y <= last_line_c ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Selectable RGB test-pattern source (checker, bars, solid cycle, gradient).
// Define VIDEO_PATTERN_GEN_GRADIENT_EN to build the mode-3 gradient; otherwise mode 3 is black.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned TILE_W     = 80,
  parameter int unsigned TILE_H     = 5,
  parameter int unsigned SOLID_HOLD = 60
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VideoReady,
  input  logic [1:0]  Mode,
  output logic [23:0] video,
  output logic        StartOfFrame,
  output logic        EndOfLine,
  output logic [7:0]  FrameCount
);

  localparam int unsigned XW   = $clog2(H_ACTIVE);
  localparam int unsigned YW   = $clog2(V_ACTIVE);
  localparam int unsigned TXW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned TYW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned HW   = (SOLID_HOLD > 1) ? $clog2(SOLID_HOLD) : 1;
  localparam int unsigned ACCW = $clog2(H_ACTIVE + 8);

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            line_end;
  logic            frame_end;
  mode_e           mode_q;
  logic [TXW-1:0]  tile_x;
  logic [TYW-1:0]  tile_y;
  logic            col_par;
  logic            row_par;
  logic [2:0]      bar;
  logic [ACCW-1:0] bar_acc;
  logic [ACCW-1:0] acc_sum;
  logic [2:0]      bar_inc;
  logic [HW-1:0]   hold;
  logic [1:0]      idx;
  rgb_t            pix;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_raster (
    .Clock       (Clock),
    .Reset       (Reset),
    .VideoReady  (VideoReady),
    .x           (x),
    .y           (y),
    .sof_c       (StartOfFrame),
    .eol_c       (EndOfLine),
    .line_end_c  (line_end),
    .frame_end_c (frame_end)
  );

  // Checker tile position; restarts at every line / frame so tiles never straddle a boundary.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tile_x  <= '0;
      col_par <= 1'b0;
      tile_y  <= '0;
      row_par <= 1'b0;
    end else if (VideoReady) begin
      if (line_end) begin
        tile_x  <= '0;
        col_par <= 1'b0;
      end else if (tile_x == TXW'(TILE_W - 1)) begin
        tile_x  <= '0;
        col_par <= ~col_par;
      end else begin
        tile_x <= tile_x + TXW'(1);
      end
      if (frame_end) begin
        tile_y  <= '0;
        row_par <= 1'b0;
      end else if (line_end) begin
        if (tile_y == TYW'(TILE_H - 1)) begin
          tile_y  <= '0;
          row_par <= ~row_par;
        end else begin
          tile_y <= tile_y + TYW'(1);
        end
      end
    end
  end

  // bar tracks floor(8x/H_ACTIVE); bar_acc holds the remainder 8x - bar*H_ACTIVE.
  always_comb begin
    acc_sum = bar_acc + ACCW'(8);
    bar_inc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc_sum >= ACCW'(H_ACTIVE)) begin
        acc_sum = acc_sum - ACCW'(H_ACTIVE);
        bar_inc = bar_inc + 3'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bar     <= '0;
      bar_acc <= '0;
    end else if (VideoReady) begin
      if (line_end) begin
        bar     <= '0;
        bar_acc <= '0;
      end else begin
        bar     <= bar + bar_inc;
        bar_acc <= acc_sum;
      end
    end
  end

  // Frame-rate state: mode is only re-sampled at frame end so a frame never mixes patterns.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mode_q     <= mode_e'(Mode);
      hold       <= '0;
      idx        <= '0;
      FrameCount <= '0;
    end else if (frame_end) begin
      mode_q     <= mode_e'(Mode);
      FrameCount <= FrameCount + 8'(1);
      if (hold == HW'(SOLID_HOLD - 1)) begin
        hold <= '0;
        idx  <= idx + 2'(1);
      end else begin
        hold <= hold + HW'(1);
      end
    end
  end

  always_comb begin
    pix = '0;
    case (mode_q)
      MODE_CHECKER:  pix = row_par ? (col_par ? P3 : P2) : (col_par ? P1 : P0);
      MODE_BARS:     pix = bar_colour(bar);
      MODE_SOLID:    pix = palette(idx);
      MODE_GRADIENT: begin
`ifdef VIDEO_PATTERN_GEN_GRADIENT_EN
        pix = '{r: 8'(x), g: 8'(y), b: FrameCount};
`else
        pix = '0;
`endif
      end
      default:       pix = '0;
    endcase
  end

`ifndef VIDEO_PATTERN_GEN_GRADIENT_EN
  logic unused_xy;
  assign unused_xy = ^{x, y};
`endif

  assign video = pix;

endmodule
